// File: rtl/egress_scheduler_if.sv
// Handshake bundle between the input-side translators, one egress scheduler and its transmitter.
// The slave modport is the scheduler's view of the bundle.
interface egress_scheduler_if #(
  parameter int NUM_PORTS   = 4,
  parameter int QUEUE_DEPTH = 8,
  parameter int ADDR_W      = 16
);
  logic [NUM_PORTS-1:0]                write_reqs_i;
  logic [NUM_PORTS-1:0][ADDR_W-1:0]    start_ptrs_i;
  logic [ADDR_W-1:0]                   tx_ptr_o;
  logic                                tx_valid_o;
  logic                                tx_ready_i;
  logic [$clog2(QUEUE_DEPTH+1)-1:0]    queue_count_o;
  logic                                drop_pulse_o;
  logic [15:0]                         drop_count_o;

  modport slave (
    input  write_reqs_i, start_ptrs_i, tx_ready_i,
    output tx_ptr_o, tx_valid_o, queue_count_o, drop_pulse_o, drop_count_o
  );

  modport master (
    output write_reqs_i, start_ptrs_i, tx_ready_i,
    input  tx_ptr_o, tx_valid_o, queue_count_o, drop_pulse_o, drop_count_o
  );
endinterface

// File: rtl/egress_scheduler.sv
// Per-output-port scheduler: one pending slot per requester, round-robin arbitration
// into an in-order show-ahead descriptor queue drained over valid/ready.
module egress_scheduler #(
  parameter int NUM_PORTS   = 4,
  parameter int QUEUE_DEPTH = 8,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  egress_scheduler_if.slave bus
);
  localparam int PTR_W  = $clog2(NUM_PORTS);
  localparam int IDX_W  = $clog2(QUEUE_DEPTH);
  localparam int CNT_W  = $clog2(QUEUE_DEPTH + 1);
  localparam int DROP_W = $clog2(NUM_PORTS + 1);

  logic [NUM_PORTS-1:0] vld_p0;
  logic [ADDR_W-1:0]    ptr_p0 [NUM_PORTS];
  logic [PTR_W-1:0]     rr_p0;

  logic [ADDR_W-1:0]    mem_p1 [QUEUE_DEPTH];
  logic [IDX_W-1:0]     head_p1;
  logic [IDX_W-1:0]     tail_p1;
  logic [CNT_W-1:0]     cnt_p1;
  logic                 vld_p1;

  logic                 pop;
  logic                 space;
  logic                 any_vld;
  logic                 grant;
  logic [PTR_W-1:0]     win;
  logic [NUM_PORTS-1:0] load;
  logic [NUM_PORTS-1:0] clr;
  logic [DROP_W-1:0]    ndrop;

  logic                 drop_pulse_q;
  logic [15:0]          drop_cnt_q;

  function automatic logic [PTR_W-1:0] wrap_port(input logic [PTR_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_PORTS) s = s - NUM_PORTS;
    return PTR_W'(s);
  endfunction

  function automatic logic [PTR_W-1:0] next_port(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_PORTS - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] p);
    return (p == IDX_W'(QUEUE_DEPTH - 1)) ? '0 : p + IDX_W'(1);
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] acc, input logic [DROP_W-1:0] n);
    logic [16:0] s;
    s = {1'b0, acc} + 17'(n);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Stage 2: arbitration over the pending slots, gated by queue space after this cycle's pop
  assign vld_p1 = (cnt_p1 != '0);
  assign pop    = vld_p1 && bus.tx_ready_i;
  assign space  = (cnt_p1 < CNT_W'(QUEUE_DEPTH)) || pop;

  always_comb begin
    any_vld = 1'b0;
    win     = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!any_vld && vld_p0[wrap_port(rr_p0, k)]) begin
        any_vld = 1'b1;
        win     = wrap_port(rr_p0, k);
      end
    end
  end

  assign grant = any_vld && space;

  // Stage 1: slot load/clear/drop decisions; a slot granted this cycle may be reloaded at once
  always_comb begin
    load  = '0;
    clr   = '0;
    ndrop = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      clr[i]  = grant && (win == PTR_W'(i));
      load[i] = bus.write_reqs_i[i] && (!vld_p0[i] || clr[i]);
      if (bus.write_reqs_i[i] && vld_p0[i] && !clr[i]) ndrop = ndrop + DROP_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0 <= '0;
      rr_p0  <= '0;
    end else begin
      vld_p0 <= load | (vld_p0 & ~clr);
      if (grant) rr_p0 <= next_port(win);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (load[i]) ptr_p0[i] <= bus.start_ptrs_i[i];
    end
  end

  // Stage 3: circular descriptor queue, pushed on grant and popped on accepted head
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_p1 <= '0;
      tail_p1 <= '0;
      cnt_p1  <= '0;
    end else begin
      if (grant) tail_p1 <= next_idx(tail_p1);
      if (pop)   head_p1 <= next_idx(head_p1);
      case ({grant, pop})
        2'b10:   cnt_p1 <= cnt_p1 + CNT_W'(1);
        2'b01:   cnt_p1 <= cnt_p1 - CNT_W'(1);
        default: cnt_p1 <= cnt_p1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (grant) mem_p1[tail_p1] <= ptr_p0[win];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_pulse_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      drop_pulse_q <= (ndrop != '0);
      drop_cnt_q   <= sat_add16(drop_cnt_q, ndrop);
    end
  end

  assign bus.tx_valid_o    = vld_p1;
  assign bus.tx_ptr_o      = vld_p1 ? mem_p1[head_p1] : '0;
  assign bus.queue_count_o = cnt_p1;
  assign bus.drop_pulse_o  = drop_pulse_q;
  assign bus.drop_count_o  = drop_cnt_q;
endmodule

// File: tb/tb_egress_scheduler.sv
// Self-checking bench for egress_scheduler: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_egress_scheduler;
  localparam int NP = 4;
  localparam int QD = 8;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  egress_scheduler_if #(.NUM_PORTS(NP), .QUEUE_DEPTH(QD), .ADDR_W(AW)) bus ();

  egress_scheduler #(.NUM_PORTS(NP), .QUEUE_DEPTH(QD), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [AW-1:0] m_fifo [$];
  bit            m_vld [NP];
  logic [AW-1:0] m_ptr [NP];
  int            m_rr;
  int            m_dc;
  bit            m_dp;
  int            m_nd;
  int            m_w;
  bit            m_pop;
  bit            m_space;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_fifo.delete();
      for (int i = 0; i < NP; i++) m_vld[i] = 0;
      m_rr = 0;
      m_dc = 0;
      m_dp = 0;
    end else begin
      m_pop   = (m_fifo.size() != 0) && bus.tx_ready_i;
      m_space = (m_fifo.size() < QD) || m_pop;
      m_w     = -1;
      for (int k = 0; k < NP; k++) begin
        if (m_w < 0 && m_vld[(m_rr + k) % NP]) m_w = (m_rr + k) % NP;
      end
      if (m_pop) void'(m_fifo.pop_front());
      if (m_w >= 0 && m_space) begin
        m_fifo.push_back(m_ptr[m_w]);
        m_vld[m_w] = 0;
        m_rr = (m_w + 1) % NP;
      end
      m_nd = 0;
      for (int i = 0; i < NP; i++) begin
        if (bus.write_reqs_i[i]) begin
          if (!m_vld[i]) begin
            m_vld[i] = 1;
            m_ptr[i] = bus.start_ptrs_i[i];
          end else begin
            m_nd++;
          end
        end
      end
      m_dc = (m_dc + m_nd > 65535) ? 65535 : m_dc + m_nd;
      m_dp = (m_nd != 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: DUT against the model on every falling edge
  always @(negedge clk) begin
    chk("tx_valid", 32'(bus.tx_valid_o), 32'(m_fifo.size() != 0));
    chk("tx_ptr", 32'(bus.tx_ptr_o), (m_fifo.size() != 0) ? 32'(m_fifo[0]) : 32'd0);
    chk("queue_count", 32'(bus.queue_count_o), 32'(m_fifo.size()));
    chk("drop_pulse", 32'(bus.drop_pulse_o), 32'(m_dp));
    chk("drop_count", 32'(bus.drop_count_o), 32'(m_dc));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic one_req(input int port, input logic [AW-1:0] p);
    bus.write_reqs_i = '0;
    bus.write_reqs_i[port] = 1'b1;
    bus.start_ptrs_i[port] = p;
  endtask

  initial begin
    bus.write_reqs_i = '0;
    bus.start_ptrs_i = '0;
    bus.tx_ready_i   = 1'b0;
    #3;
    chk("rst_valid", 32'(bus.tx_valid_o), 32'd0);
    chk("rst_ptr", 32'(bus.tx_ptr_o), 32'd0);
    chk("rst_count", 32'(bus.queue_count_o), 32'd0);
    chk("rst_dpulse", 32'(bus.drop_pulse_o), 32'd0);
    chk("rst_dcount", 32'(bus.drop_count_o), 32'd0);
    do_reset();

    // Single request, one-cycle latency
    bus.tx_ready_i = 1'b1;
    one_req(0, 16'h0012);
    tick();
    bus.write_reqs_i = '0;
    chk("single_not_yet", 32'(bus.tx_valid_o), 32'd0);
    tick();
    chk("single_valid", 32'(bus.tx_valid_o), 32'd1);
    chk("single_ptr", 32'(bus.tx_ptr_o), 32'h12);
    tick();
    chk("single_gone", 32'(bus.tx_valid_o), 32'd0);
    chk("single_count0", 32'(bus.queue_count_o), 32'd0);

    // Simultaneous burst drains in port order
    do_reset();
    bus.tx_ready_i = 1'b0;
    bus.write_reqs_i = 4'b1111;
    bus.start_ptrs_i[0] = 16'h00A0;
    bus.start_ptrs_i[1] = 16'h00B0;
    bus.start_ptrs_i[2] = 16'h00C0;
    bus.start_ptrs_i[3] = 16'h00D0;
    tick();
    bus.write_reqs_i = '0;
    for (int k = 0; k < 4; k++) tick();
    chk("burst_count", 32'(bus.queue_count_o), 32'd4);
    bus.tx_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("burst_order", 32'(bus.tx_ptr_o), 32'h00A0 + 32'(k) * 32'h10);
      tick();
    end
    chk("burst_empty", 32'(bus.queue_count_o), 32'd0);

    // Round-robin: after port 2 wins, port 3 precedes port 0
    one_req(2, 16'h0022);
    tick();
    bus.write_reqs_i = '0;
    tick();
    chk("rr_p2", 32'(bus.tx_ptr_o), 32'h22);
    bus.write_reqs_i = 4'b1001;
    bus.start_ptrs_i[0] = 16'h0030;
    bus.start_ptrs_i[3] = 16'h0033;
    tick();
    bus.write_reqs_i = '0;
    tick();
    chk("rr_first_p3", 32'(bus.tx_ptr_o), 32'h33);
    tick();
    chk("rr_then_p0", 32'(bus.tx_ptr_o), 32'h30);
    tick();

    // Full queue plus occupied slots, then a drop, then lossless drain
    do_reset();
    bus.tx_ready_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      one_req(i % 4, 16'h0040 + 16'(i));
      tick();
    end
    one_req(0, 16'h0099);
    tick();
    bus.write_reqs_i = '0;
    chk("full_count", 32'(bus.queue_count_o), 32'd8);
    chk("full_dpulse", 32'(bus.drop_pulse_o), 32'd1);
    chk("full_dcount", 32'(bus.drop_count_o), 32'd1);
    bus.tx_ready_i = 1'b1;
    for (int k = 0; k < 12; k++) begin
      chk("full_drain", 32'(bus.tx_ptr_o), 32'h40 + 32'(k));
      tick();
    end
    chk("full_drained", 32'(bus.tx_valid_o), 32'd0);

    // Streaming one per cycle
    for (int k = 0; k <= 20; k++) begin
      if (k < 20) one_req(k % 4, 16'h0100 + 16'(k));
      else bus.write_reqs_i = '0;
      tick();
      if (k >= 1) begin
        chk("stream_ptr", 32'(bus.tx_ptr_o), 32'h100 + 32'(k) - 32'd1);
        chk("stream_count", 32'(bus.queue_count_o), 32'd1);
      end
    end
    tick();
    chk("stream_drops", 32'(bus.drop_count_o), 32'd1);

    // Reset mid-operation
    bus.tx_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      one_req(k % 4, 16'h0200 + 16'(k));
      tick();
    end
    bus.write_reqs_i = 4'b0110;
    bus.start_ptrs_i[1] = 16'h0301;
    bus.start_ptrs_i[2] = 16'h0302;
    tick();
    bus.write_reqs_i = '0;
    chk("mid_count5", 32'(bus.queue_count_o), 32'd5);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(bus.tx_valid_o), 32'd0);
    chk("mid_rst_count", 32'(bus.queue_count_o), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    bus.tx_ready_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("post_rst_idle", 32'(bus.tx_valid_o), 32'd0);
    end

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 < 250) bus.write_reqs_i = 4'($urandom) & 4'($urandom);
      else bus.write_reqs_i = 4'($urandom);
      for (int i = 0; i < NP; i++) bus.start_ptrs_i[i] = 16'($urandom);
      bus.tx_ready_i = (c % 700 < 350) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      tick();
    end
    bus.write_reqs_i = '0;
    bus.tx_ready_i = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    chk("rand_drained", 32'(bus.tx_valid_o), 32'd0);

    // Drop counter saturation
    do_reset();
    bus.tx_ready_i = 1'b0;
    bus.write_reqs_i = 4'b1111;
    for (int c = 0; c < 16400; c++) tick();
    bus.write_reqs_i = '0;
    tick();
    chk("drop_saturate", 32'(bus.drop_count_o), 32'hFFFF);
    chk("sat_count", 32'(bus.queue_count_o), 32'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/egress_scheduler.md
# egress_scheduler

Per-output-port scheduler between the input-side translators and the egress transmitter. Collects the single-cycle write requests and buffer start pointers that every input port's translator raises for this output port. Arbitrates them round-robin into an in-order descriptor queue, and hands descriptors one at a time to the transmitter over a valid/ready handshake. One instance exists per output port.

## Interface
- NUM_PORTS, 4, number of requesting input ports (translators); power of two not required, ≥2
- QUEUE_DEPTH, 8, descriptor queue entries; ≥2
- ADDR_W, from mem_pkg, width of a buffer start pointer
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- write_reqs_i  in  NUM_PORTS  bit i: one-cycle request from input port i's translator targeting this output port
- start_ptrs_i  in  NUM_PORTS x ADDR_W  start pointer from port i; sampled only when write_reqs_i[i]=1
- tx_ptr_o  out  ADDR_W  head descriptor's start pointer; 0 when tx_valid_o=0
- tx_valid_o  out  1  head descriptor present
- tx_ready_i  in  1  transmitter accepts head this cycle
- queue_count_o  out  $clog2(QUEUE_DEPTH+1)  descriptors currently queued
- drop_pulse_o  out  1  one-cycle pulse: ≥1 request dropped in the previous cycle
- drop_count_o  out  16  total dropped requests, saturates at 0xFFFF

## Operation
- Stage 1, pending slots: one slot per requester (valid bit + ADDR_W pointer).
  - write_reqs_i[i]=1 with slot i empty, or slot i granted this same cycle: load start_ptrs_i[i], set valid.
  - write_reqs_i[i]=1 with slot i occupied and not granted this cycle: request dropped, slot unchanged.
- Drop accounting: drop_count_o += number of drops in the cycle, saturating at 0xFFFF. drop_pulse_o=1 on the following cycle.
- Stage 2, arbiter: at most one grant per cycle.
  - Grant condition: any slot valid AND queue has space after this cycle's pop, i.e. queue_count_o<QUEUE_DEPTH OR (tx_valid_o AND tx_ready_i).
  - Winner: first valid slot at index ≥ rr_ptr, wrapping modulo NUM_PORTS.
  - On grant: winner's slot cleared (unless reloaded the same cycle), its pointer written to the queue tail, rr_ptr ← (winner+1) mod NUM_PORTS.
  - rr_ptr unchanged when there is no grant.
- Stage 3, descriptor queue: circular, show-ahead FIFO with head/tail indices wrapping at QUEUE_DEPTH.
  - tx_valid_o = (count≠0).
  - Pop when tx_valid_o AND tx_ready_i. Push on grant.
  - Simultaneous push and pop: count unchanged. Push into a full queue is allowed only with a same-cycle pop.
- Ordering: descriptors leave in grant order. Pointers are never duplicated or lost except by a counted drop.
- tx_ready_i while tx_valid_o=0: ignored.

## Timing
- Reset (async assert, sync-safe deassert): all slots empty, queue empty, rr_ptr=0. Outputs: tx_valid_o=0, tx_ptr_o=0, queue_count_o=0, drop_pulse_o=0, drop_count_o=0.
- Reset mid-operation discards all pending and queued descriptors; none reappear after release.
- Minimum latency: request sampled at edge N → slot valid after N → granted and pushed at edge N+1 → tx_valid_o=1 with that pointer after edge N+1. The descriptor is visible on the cycle following the request cycle.
- Queue backpressure stalls grants. Slots then hold; new requests to occupied slots drop.
- Once tx_valid_o=1, it stays 1 and tx_ptr_o stays stable until a pop.
- Sustained throughput: 1 descriptor per cycle in and out with tx_ready_i held at 1.
- queue_count_o and drop_count_o are registered and reflect state after the last edge.

## Test plan
- Single request: write_reqs_i=0001, start_ptrs_i[0]=0x12, tx_ready_i=1 → tx_valid_o=1, tx_ptr_o=0x12 one cycle later for exactly one cycle; queue_count_o returns to 0.
- Simultaneous burst: write_reqs_i=1111 with ptrs 0xA0,0xB0,0xC0,0xD0 after reset, tx_ready_i=0 → four pushes on consecutive cycles in order 0xA0,0xB0,0xC0,0xD0; queue_count_o=4. Raising tx_ready_i then drains them in that order.
- Round-robin fairness: after port 2 wins (rr_ptr=3), requests from ports 0 and 3 in the same cycle → port 3 descriptor queued before port 0.
- Full and drop, QUEUE_DEPTH=8, tx_ready_i=0:
  - Fill 8 entries plus occupied slots.
  - Further write_reqs_i=0001 → drop_pulse_o=1 one cycle later, drop_count_o=1, queue_count_o stays 8.
  - tx_ready_i=1 → all queued and pending pointers emerge in order; none lost.
- Streaming: one request per cycle rotating ports 0..3 with tx_ready_i=1 for 20 cycles → 20 descriptors out, one per cycle, queue_count_o ≤1, drop_count_o=0.
- Reset mid-operation: 5 queued plus 2 pending, assert rst → tx_valid_o=0 and queue_count_o=0 immediately. After release with no requests, tx_valid_o stays 0 for 10 cycles.
